// File: rtl/output_queue.sv
`default_nettype none
// ============================================================================
// output_queue : prefill-then-stream sample FIFO feeding a DAC-rate consumer
// Revision 1.0
// ============================================================================
module output_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int PREFILL    = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_strobe,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  streaming,
  output logic                  underflow,
  input  logic                  clear_underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);

  typedef enum logic [0:0] {
    FILLING   = 1'b0,
    STREAMING = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic do_write;
  logic do_read;
  logic underflow_event;

  // Ready comes only from the registered level, so a same-cycle read never frees a slot.
  assign in_ready  = (level < DEPTH_LVL);
  assign streaming = (state == STREAMING);

  always_comb begin
    state_next      = state;
    do_write        = in_valid && in_ready;
    do_read         = 1'b0;
    underflow_event = 1'b0;
    case (state)
      FILLING: begin
        if (level >= PREFILL_LVL) state_next = STREAMING;
      end
      STREAMING: begin
        if (sample_tick) begin
          if (level != '0) begin
            do_read = 1'b1;
          end else begin
            underflow_event = 1'b1;
            state_next      = FILLING;
          end
        end
      end
      default: state_next = FILLING;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= FILLING;
    else          state <= state_next;
  end

  // Storage is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (reset_n && do_write) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Every tick produces a strobe; only a tick that actually reads yields real data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out   <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= sample_tick;
      if (sample_tick) data_out <= do_read ? mem[rd_ptr] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)             underflow <= 1'b0;
    else if (underflow_event) underflow <= 1'b1;
    else if (clear_underflow) underflow <= 1'b0;
  end

endmodule
`default_nettype wire
